// File: rtl/dmem_ctrl.sv
// Data-memory controller: word-organised RAM behind a valid/ready request port,
// RV32I byte/half/word access with extension, error checking and wait states.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [63:0] BYTES = 64'(DEPTH_WORDS) * 64'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, commit;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;
    logic        c_we;
    logic [2:0]  c_f3;
    logic [31:0] c_addr, c_wdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wword, rword, ldata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        accept    = req_valid & req_ready;
    end

    // With no wait states the commit edge is the acceptance edge itself, so the
    // live request fields are used in IDLE and the registered copy afterwards.
    always_comb begin
        c_we    = (state == IDLE) ? req_we     : r_we;
        c_f3    = (state == IDLE) ? req_funct3 : r_f3;
        c_addr  = (state == IDLE) ? req_addr   : r_addr;
        c_wdata = (state == IDLE) ? req_wdata  : r_wdata;
        idx     = c_addr[AW+1:2];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        err   = ({32'd0, c_addr} >= BYTES);
        be    = 4'b0000;
        wword = c_wdata;
        case (c_f3)
            3'b000: begin
                be    = 4'b0001 << c_addr[1:0];
                wword = {4{c_wdata[7:0]}};
            end
            3'b001: begin
                be    = c_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{c_wdata[15:0]}};
                if (c_addr[0]) err = 1'b1;
            end
            3'b010: begin
                be = 4'b1111;
                if (c_addr[1:0] != 2'b00) err = 1'b1;
            end
            3'b100: if (c_we) err = 1'b1;
            3'b101: if (c_we || c_addr[0]) err = 1'b1;
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        rword = mem[idx];
        case (c_addr[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = c_addr[1] ? rword[31:16] : rword[15:0];
        case (c_f3)
            3'b000:  ldata = {{24{rbyte[7]}}, rbyte};
            3'b100:  ldata = {24'd0, rbyte};
            3'b001:  ldata = {{16{rhalf[15]}}, rhalf};
            3'b101:  ldata = {16'd0, rhalf};
            default: ldata = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_we      <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (err || c_we) ? '0 : ldata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && commit && c_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance 0 has no wait states, instance 1 has three.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(32), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(32), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    // One transaction; request fields are scrambled right after acceptance.
    task automatic req(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int nlow);
        bit got;
        int k;
        rdata = '0; err = 1'b0; lat = 0; nlow = 0; got = 0; k = 0;
        @(negedge clk);
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        req_we[d] = we; req_funct3[d] = f3; req_addr[d] = addr; req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        @(posedge clk);
        for (k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid[d] = 1'b0; req_we[d] = ~we; req_funct3[d] = 3'b011;
                req_addr[d] = addr ^ 32'h4; req_wdata[d] = ~wdata;
            end
            if (rsp_valid[d] && !got) begin
                got = 1; lat = k; rdata = rsp_rdata[d]; err = rsp_err[d];
            end
            if (req_ready[d]) break;
            nlow++;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_funct3[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vecs++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
                errs++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat, nl;
        req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat, nl);
        vecs++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'h0) begin
            errs++; $display("FAIL sw_word: lat=%0d err=%b rdata=%h, want 1 0 00000000", lat, e, rd);
        end
        req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, nl);
        vecs++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errs++; $display("FAIL lw_word: lat=%0d err=%b rdata=%h, want 1 0 deadbeef", lat, e, rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic e; int lat, nl;
        logic [2:0]  f3  [7] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b100};
        logic [31:0] ad  [7] = '{32'h20, 32'h21, 32'h21, 32'h20, 32'h22, 32'h22, 32'h7F};
        logic [31:0] exp [7] = '{32'h1122AA44, 32'hFFFFFFAA, 32'h000000AA, 32'h8001AA44,
                                 32'hFFFF8001, 32'h00008001, 32'h0000007F};
        req(0, 1'b1, 3'b010, 32'h20, 32'h11223344, rd, e, lat, nl);
        req(0, 1'b1, 3'b000, 32'h21, 32'h000000AA, rd, e, lat, nl);
        req(0, 1'b1, 3'b000, 32'h7F, 32'h1234567F, rd, e, lat, nl);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) req(0, 1'b1, 3'b001, 32'h22, 32'hFFFF8001, rd, e, lat, nl);
            req(0, 1'b0, f3[i], ad[i], 32'h0, rd, e, lat, nl);
            vecs++;
            if (rd !== exp[i] || e !== 1'b0) begin
                errs++;
                $display("FAIL byte_lane_%0d f3=%b addr=%h: rdata=%h err=%b, want %h 0",
                         i, f3[i], ad[i], rd, e, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat, nl;
        logic        we  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3  [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] ad  [6] = '{32'h23, 32'h22, 32'h80, 32'h20, 32'h20, 32'h80};
        for (int i = 0; i < 6; i++) begin
            req(0, we[i], f3[i], ad[i], 32'h00000055, rd, e, lat, nl);
            vecs++;
            if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                errs++;
                $display("FAIL err_case_%0d: err=%b rdata=%h lat=%0d, want 1 00000000 1", i, e, rd, lat);
            end
        end
        req(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat, nl);
        vecs++;
        if (rd !== 32'h8001AA44 || e !== 1'b0) begin
            errs++; $display("FAIL err_no_write: rdata=%h err=%b, want 8001aa44 0", rd, e);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic e; int lat, nl;
        req(1, 1'b1, 3'b010, 32'h34, 32'hA5A5A5A5, rd, e, lat, nl);
        req(1, 1'b1, 3'b010, 32'h30, 32'h12345678, rd, e, lat, nl);
        vecs++;
        if (lat !== 4 || nl !== 4) begin
            errs++; $display("FAIL ws_store_timing: lat=%0d ready_low=%0d, want 4 4", lat, nl);
        end
        req(1, 1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat, nl);
        vecs++;
        if (rd !== 32'h12345678 || e !== 1'b0 || lat !== 4 || nl !== 4) begin
            errs++;
            $display("FAIL ws_load: rdata=%h err=%b lat=%0d ready_low=%0d, want 12345678 0 4 4", rd, e, lat, nl);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic e; int lat, nl, seen;
        req(1, 1'b1, 3'b010, 32'h04, 32'h11111111, rd, e, lat, nl);
        req(1, 1'b0, 3'b010, 32'h04, 32'h0, rd, e, lat, nl);
        @(negedge clk);
        req_we[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = 32'h04;
        req_wdata[1] = 32'hCAFEF00D; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0; rst_n[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        vecs++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0) begin
            errs++;
            $display("FAIL midop_reset_state: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        vecs++;
        if (seen !== 0) begin
            errs++; $display("FAIL midop_no_rsp: rsp_valid pulses=%0d, want 0", seen);
        end
        req(1, 1'b0, 3'b010, 32'h04, 32'h0, rd, e, lat, nl);
        vecs++;
        if (rd !== 32'h11111111 || e !== 1'b0) begin
            errs++; $display("FAIL midop_no_write: rdata=%h err=%b, want 11111111 0", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad  [4] = '{32'h34, 32'h04, 32'h30, 32'h04};
        logic [31:0] exp [4] = '{32'hA5A5A5A5, 32'h11111111, 32'h12345678, 32'h11111111};
        int acc_cyc [4];
        int nacc = 0, nrsp = 0, cyc = 0;
        @(negedge clk);
        req_we[1] = 1'b0; req_funct3[1] = 3'b010;
        while ((nacc < 4 || nrsp < 4) && cyc < 100) begin
            if (rsp_valid[1]) begin
                vecs++;
                if (nrsp >= 4 || rsp_rdata[1] !== exp[nrsp] || rsp_err[1] !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_rsp_%0d: rdata=%h err=%b, want %h 0", nrsp, rsp_rdata[1], rsp_err[1],
                             exp[nrsp % 4]);
                end
                nrsp++;
            end
            if (req_ready[1]) begin
                if (nacc < 4) begin
                    req_addr[1] = ad[nacc]; req_valid[1] = 1'b1;
                    acc_cyc[nacc] = cyc; nacc++;
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[1] = 1'b0;
        vecs++;
        if (nacc !== 4 || nrsp !== 4) begin
            errs++; $display("FAIL b2b_count: accepted=%0d responses=%0d, want 4 4", nacc, nrsp);
        end else begin
            for (int i = 1; i < 4; i++) begin
                vecs++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
                    errs++; $display("FAIL b2b_spacing_%0d: %0d cycles, want 5", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_errors();
        test_wait_states();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
